// File: rtl/playfield_pkg.sv
// Shared constants and helpers for the playfield occupancy path.
package playfield_pkg;

    localparam int EMPTY_WALL  = 0;
    localparam int EMPTY_BRICK = 1;
    localparam int EMPTY_PAD   = 2;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Linear brick index (row-major) for a pixel already known to lie inside the field.
    function automatic int brick_index(input int x, input int y, input int left, input int top,
                                       input int w_log2, input int h_log2, input int cols);
        return ((y - top) >> h_log2) * cols + ((x - left) >> w_log2);
    endfunction

endpackage

// File: rtl/playfield_map_brick_map.sv
// Brick live-bit store: one scan read port, one hit lookup port, one clear port and a refill.
module brick_map
    import playfield_pkg::*;
#(
    parameter int COLS = 16,
    parameter int ROWS = 8,
    parameter int IW   = $clog2(COLS * ROWS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          refill,
    input  logic          clr_en,
    input  logic [IW-1:0] clr_idx,
    input  logic [IW-1:0] rd_idx,
    input  logic [IW-1:0] hit_idx,
    output logic          rd_live,
    output logic          hit_live
);

    localparam int NB = COLS * ROWS;

    logic [NB-1:0] live;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live <= '1;
        end else if (refill) begin
            live <= '1;
        end else if (clr_en) begin
            live[clr_idx] <= 1'b0;
        end
    end

    assign rd_live  = live[rd_idx];
    assign hit_live = live[hit_idx];

endmodule

// File: rtl/playfield_map.sv
// Playfield occupancy: per-pixel wall/brick/paddle code, brick clearing on vblank hits,
// brick/score counters and the per-frame move strobe.
module playfield_map
    import playfield_pkg::*;
#(
    parameter int BRICK_COLS = 16,
    parameter int BRICK_ROWS = 8,
    parameter int BRICK_W    = 32,
    parameter int BRICK_H    = 16,
    parameter int BRICK_LEFT = 64,
    parameter int BRICK_TOP  = 48,
    parameter int WALL       = 8,
    parameter int PAD_Y      = 448,
    parameter int PAD_HALF   = 24,
    parameter int MOVE_DIV   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pixpulse,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic [9:0]  paddle_x,
    input  logic        restart,
    input  logic        hit_valid,
    input  logic [9:0]  hit_x,
    input  logic [9:0]  hit_y,
    output logic        hit_ready,
    output logic [2:0]  empty,
    output logic        move,
    output logic        brick_cleared,
    output logic [7:0]  bricks_left,
    output logic [15:0] score,
    output logic        all_clear
);

    localparam int NB      = BRICK_COLS * BRICK_ROWS;
    localparam int IW      = $clog2(NB);
    localparam int WB      = $clog2(BRICK_W);
    localparam int HB      = $clog2(BRICK_H);
    localparam int FIELD_R = BRICK_LEFT + BRICK_COLS * BRICK_W;
    localparam int FIELD_B = BRICK_TOP + BRICK_ROWS * BRICK_H;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic in_field(input int x, input int y);
        return (x >= BRICK_LEFT) && (x < FIELD_R) && (y >= BRICK_TOP) && (y < FIELD_B);
    endfunction

    int sx, sy, px, hx, hy, pad_dx;
    logic          scan_in, scan_gap, scan_live;
    logic          hit_in, hit_live, accept;
    logic [IW-1:0] scan_idx, hit_idx;
    logic [2:0]    empty_c;
    logic [3:0]    frame_cnt;

    always_comb begin
        sx       = int'(hcount);
        sy       = int'(vcount);
        px       = int'(paddle_x);
        hx       = int'(hit_x);
        hy       = int'(hit_y);
        pad_dx   = sx - px;
        scan_in  = in_field(sx, sy);
        hit_in   = in_field(hx, hy);
        // The last pixel column and row of each brick are a gap between bricks.
        scan_gap = (((sx - BRICK_LEFT) & (BRICK_W - 1)) == BRICK_W - 1) ||
                   (((sy - BRICK_TOP) & (BRICK_H - 1)) == BRICK_H - 1);
        scan_idx = '0;
        hit_idx  = '0;
        if (scan_in) scan_idx = IW'(brick_index(sx, sy, BRICK_LEFT, BRICK_TOP, WB, HB, BRICK_COLS));
        if (hit_in)  hit_idx  = IW'(brick_index(hx, hy, BRICK_LEFT, BRICK_TOP, WB, HB, BRICK_COLS));
    end

    brick_map #(
        .COLS (BRICK_COLS),
        .ROWS (BRICK_ROWS),
        .IW   (IW)
    ) u_brick_map (
        .clk      (clk),
        .rst_n    (rst_n),
        .refill   (restart),
        .clr_en   (accept),
        .clr_idx  (hit_idx),
        .rd_idx   (scan_idx),
        .hit_idx  (hit_idx),
        .rd_live  (scan_live),
        .hit_live (hit_live)
    );

    always_comb begin
        empty_c = 3'b111;
        if (sx < SCREEN_W && sy < SCREEN_H) begin
            if (sx < WALL || sx >= SCREEN_W - WALL || sy < WALL)
                empty_c[EMPTY_WALL] = 1'b0;
            if (scan_in && !scan_gap && scan_live)
                empty_c[EMPTY_BRICK] = 1'b0;
            if (sy >= PAD_Y && sy <= PAD_Y + 7 && pad_dx <= PAD_HALF && pad_dx >= -PAD_HALF)
                empty_c[EMPTY_PAD] = 1'b0;
        end
    end

    assign empty     = empty_c;
    assign hit_ready = (sy >= SCREEN_H) && !restart;
    assign accept    = hit_valid && hit_ready && hit_in && hit_live;
    assign all_clear = (bricks_left == 8'd0);

    // Hit side: counters update one clock after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bricks_left   <= 8'(NB);
            score         <= 16'd0;
            brick_cleared <= 1'b0;
        end else begin
            brick_cleared <= accept;
            if (restart) begin
                bricks_left <= 8'(NB);
                score       <= 16'd0;
            end else if (accept) begin
                bricks_left <= bricks_left - 8'd1;
                score       <= sat_inc(score);
            end
        end
    end

    // Frame divider: move rises on the (0,480) pixel edge of every MOVE_DIV-th frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 4'd0;
            move      <= 1'b0;
        end else if (pixpulse) begin
            move <= 1'b0;
            if (hcount == 10'd0 && vcount == 10'd480) begin
                if (frame_cnt == 4'(MOVE_DIV - 1)) begin
                    frame_cnt <= 4'd0;
                    move      <= 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + 4'd1;
                end
            end
        end
    end

endmodule
